pipelined_risc_v_core_v2: RTL
=============================

# pipelined_risc_v_core_v2

Parametrised second-generation pipelined RISC-V integer core with a 4-stage IF/ID/EX/WB pipeline. It executes a subset of RV32I register, immediate, branch and ECALL instructions on an XLEN-bit datapath. Programs are loaded byte-wise into an internal program memory. The core supports full forwarding, taken-branch flush, run/stall gating, halt on ECALL, and a retired-instruction counter. It replaces the fixed 8-bit, non-branching core as the chip top-level compute block.

## Interface
- XLEN, 8, datapath and register width (8..32)
- NREGS, 32, architectural registers; address width REG_AW = $clog2(NREGS)
- PM_ADDR_WIDTH, 7, program-memory byte address width (2^PM_ADDR_WIDTH bytes)
- CNT_WIDTH, 16, retired-counter width

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- run  in  1  1 = pipeline advances; 0 = whole pipeline frozen
- pm_wr_en  in  1  program-memory byte write enable
- pm_wr_addr  in  PM_ADDR_WIDTH  byte write address
- pm_wr_data  in  8  byte write data
- alu_result  out  XLEN  EX/WB result register
- wb_valid  out  1  EX/WB holds a valid writing instruction this cycle
- halted  out  1  ECALL retired; core stopped until rst
- retired_count  out  CNT_WIDTH  instructions retired, saturating
- dbg_pc  out  PM_ADDR_WIDTH  current fetch PC

## Operation
- Program memory:
  - Little-endian bytes; the instruction at PC is bytes PC..PC+3, with addresses wrapping modulo 2^PM_ADDR_WIDTH.
  - Read is combinational. Write is accepted on any cycle, including during reset.
- Decoded instructions; all other encodings are NOPs with no write:
  - OP (0110011): ADD, SUB (funct7[5]=1), SLL, XOR, SRL, OR, AND.
  - OP-IMM (0010011): ADDI, XORI, ORI, ANDI, SLLI, SRLI.
  - BRANCH (1100011): BEQ (funct3 000), BNE (funct3 001).
  - ECALL: exactly 0x00000073.
- Arithmetic: modulo 2^XLEN. I-immediate is inst[31:20] sign-extended/truncated to XLEN. Shift amount is op2[$clog2(XLEN)-1:0].
- x0 reads as 0. Writes to x0 are dropped, and rd=0 never forwards.
- Register file is reset to all zeros. The write port is in WB.
- Forwarding:
  - EX operands take the EX/WB result when its rd matches rs and the instruction writes.
  - ID reads bypass the same-cycle WB write (write-through).
  - Result: no data-hazard stalls.
- Branch resolves in EX with target = branch PC + B-immediate (bytes, wrapped). When taken, IF/ID and ID/EX are flushed and PC loads the target.
- ECALL reaching EX:
  - Sets halted, flushes the younger stages and freezes PC.
  - Retires; no register write.
- run=0: PC, all pipeline registers, the register-file write and the counter hold. Outputs hold their values.
- retired_count increments once per valid (non-bubble) instruction leaving EX, and saturates at all-ones.

## Timing
- Reset values:
  - PC=0, all stage valids=0, alu_result=0, wb_valid=0, halted=0, retired_count=0.
  - Register file is cleared.
  - Program memory is not cleared.
- rst asserted mid-operation clears state on that edge. In-flight instructions are discarded.
- Latency from the first rising edge with run=1 after reset:
  - Instruction at PC 0 appears on alu_result/wb_valid after the 3rd edge.
  - Throughput is 1 instruction/cycle.
- Taken branch: exactly 2 bubble cycles (wb_valid=0) before the target result. A not-taken branch costs 0 cycles.
- Branches and NOPs retire with wb_valid=0. alu_result holds its previous value during these cycles.
- pm write and fetch of the same byte in the same cycle: fetch sees the old byte.
- Flush and ECALL in the same stage are impossible. A taken branch in EX flushes an ECALL that is in ID.
- Once halted=1, run is ignored and only rst clears it.

## Structure
- Package pipelined_core_pkg holds:
  - Opcode and funct3 localparams and the ECALL constant.
  - alu_op_t enum: ADD, SUB, SLL, XOR, SRL, OR, AND, PASS.
  - The ID/EX bundle struct.
- Sub-module core_hazard_unit (combinational) holds the forwarding selects, write-through compare and flush generation.
- The ALU, decoder and pipeline registers stay in the top level.

## Test plan
- Load ADDI x1,x0,5; ADDI x2,x0,3; ADD x3,x1,x2; SUB x4,x2,x1 (XLEN=8), then run=1 → alu_result 0x05, 0x03, 0x08, 0xFE on edges 3–6, with wb_valid=1 each cycle and retired_count=4.
- ADDI x1,x0,1; BEQ x1,x1,+12; two ADDI x5 instructions; ADDI x6,x0,7 → wb_valid low for 2 cycles after the branch, then 0x07; x5 is never written.
- Same program with BNE → not taken; both x5 writes are seen back-to-back with no bubbles.
- ADDI x0,x0,9 then ADD x1,x0,x0 → x1=0, and the x0 write does not forward.
- ECALL followed by ADDI x1,x0,3 → halted=1 two edges after ECALL enters IF/ID; dbg_pc frozen; x1 stays 0; toggling run has no effect; rst clears halted.
- run=0 for 3 cycles mid-stream, then rst pulsed during a taken branch → outputs hold while stalled; after rst, PC=0, all outputs 0, and execution restarts from byte 0.

Source files
------------

// File: rtl/pipelined_risc_v_core_v2_pkg.sv
// pipelined_core_pkg
// Shared definitions for the pipelined RISC-V core:
//   - RV32I opcode / funct3 / funct7 encodings used by the decoder
//   - the ECALL encoding (only the exact word is recognised)
//   - alu_op_t, the operation selected in ID and carried to EX
//   - id_ex_ctrl_t, the control half of the ID/EX pipeline register
//     (the XLEN-wide operand data lives beside it in the top level,
//     because it depends on the top-level XLEN parameter)
package pipelined_core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;

    // Register specifiers are carried at their encoded width; the top
    // level slices them down to the register-file address width.
    localparam int RF_FIELD_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_XOR,
        ALU_SRL,
        ALU_OR,
        ALU_AND,
        ALU_PASS
    } alu_op_t;

    typedef struct packed {
        logic                  valid;      // slot holds a real instruction
        alu_op_t               alu_op;
        logic                  writes;     // decoded as a register-writing op
        logic                  use_imm;    // op2 = I-immediate instead of rs2
        logic                  is_branch;
        logic                  br_ne;      // BNE when set, BEQ otherwise
        logic                  is_ecall;
        logic [RF_FIELD_W-1:0] rd;
        logic [RF_FIELD_W-1:0] rs1;
        logic [RF_FIELD_W-1:0] rs2;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
        valid:     1'b0,
        alu_op:    ALU_PASS,
        writes:    1'b0,
        use_imm:   1'b0,
        is_branch: 1'b0,
        br_ne:     1'b0,
        is_ecall:  1'b0,
        rd:        '0,
        rs1:       '0,
        rs2:       '0
    };

endpackage

// File: rtl/pipelined_risc_v_core_v2_hazard.sv
// core_hazard_unit
// Purely combinational hazard logic for the 4-stage core.
// Ports:
//   exwb_valid   in   EX/WB holds a register-writing instruction
//   exwb_rd      in   destination of the EX/WB instruction
//   idex_rs1/2   in   source specifiers of the instruction in EX
//   ifid_rs1/2   in   source specifiers of the instruction in ID
//   ex_taken     in   branch in EX is valid and taken
//   ex_ecall     in   ECALL is valid in EX
//   wb_we        out  register-file write strobe (before run gating)
//   fwd_rs1/2    out  EX operand takes the EX/WB result
//   wt_rs1/2     out  ID read takes the same-cycle WB write data
//   flush_front  out  squash IF/ID and ID/EX on the next advance
module core_hazard_unit
    import pipelined_core_pkg::*;
(
    input  logic                  exwb_valid,
    input  logic [RF_FIELD_W-1:0] exwb_rd,
    input  logic [RF_FIELD_W-1:0] idex_rs1,
    input  logic [RF_FIELD_W-1:0] idex_rs2,
    input  logic [RF_FIELD_W-1:0] ifid_rs1,
    input  logic [RF_FIELD_W-1:0] ifid_rs2,
    input  logic                  ex_taken,
    input  logic                  ex_ecall,
    output logic                  wb_we,
    output logic                  fwd_rs1,
    output logic                  fwd_rs2,
    output logic                  wt_rs1,
    output logic                  wt_rs2,
    output logic                  flush_front
);

    always_comb begin
        // x0 is never a real destination: it neither writes nor forwards.
        wb_we       = exwb_valid && (exwb_rd != '0);
        fwd_rs1     = wb_we && (exwb_rd == idex_rs1);
        fwd_rs2     = wb_we && (exwb_rd == idex_rs2);
        wt_rs1      = wb_we && (exwb_rd == ifid_rs1);
        wt_rs2      = wb_we && (exwb_rd == ifid_rs2);
        flush_front = ex_taken || ex_ecall;
    end

endmodule

// File: rtl/pipelined_risc_v_core_v2.sv
// pipelined_risc_v_core_v2
// 4-stage (IF / ID / EX / WB) RV32I-subset integer core, XLEN-bit datapath,
// with a byte-writable internal program memory.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   run            in   1 = pipeline advances, 0 = everything holds
//   pm_wr_en       in   program-memory byte write enable (works in reset)
//   pm_wr_addr     in   program-memory byte address
//   pm_wr_data     in   program-memory byte data
//   alu_result     out  EX/WB result register
//   wb_valid       out  EX/WB holds a valid register-writing instruction
//   halted         out  ECALL retired; only rst releases the core
//   retired_count  out  saturating count of instructions leaving EX
//   dbg_pc         out  current fetch PC
//
// Stage-valid semantics: every pipeline register carries a valid bit. A
// slot with valid=0 is a bubble: it never writes, never forwards, never
// branches, never halts and is not counted. Slots move forward only on an
// edge where advance (run && !halted) is 1; otherwise every stage holds.
module pipelined_risc_v_core_v2
    import pipelined_core_pkg::*;
#(
    parameter int XLEN          = 8,
    parameter int NREGS         = 32,
    parameter int PM_ADDR_WIDTH = 7,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     pm_wr_en,
    input  logic [PM_ADDR_WIDTH-1:0] pm_wr_addr,
    input  logic [7:0]               pm_wr_data,
    output logic [XLEN-1:0]          alu_result,
    output logic                     wb_valid,
    output logic                     halted,
    output logic [CNT_WIDTH-1:0]     retired_count,
    output logic [PM_ADDR_WIDTH-1:0] dbg_pc
);

    localparam int REG_AW   = $clog2(NREGS);
    localparam int SH_W     = $clog2(XLEN);
    localparam int PM_BYTES = 1 << PM_ADDR_WIDTH;

    // ---------------- state ----------------
    logic [7:0]               pm [PM_BYTES];
    logic [XLEN-1:0]          rf [NREGS];
    logic [PM_ADDR_WIDTH-1:0] pc;

    logic                     ifid_valid;
    logic [31:0]              ifid_inst;
    logic [PM_ADDR_WIDTH-1:0] ifid_pc;

    id_ex_ctrl_t              idex;
    logic [XLEN-1:0]          idex_rs1_val;
    logic [XLEN-1:0]          idex_rs2_val;
    logic [XLEN-1:0]          idex_imm;
    logic [PM_ADDR_WIDTH-1:0] idex_br_target;

    logic                     exwb_valid;
    logic [RF_FIELD_W-1:0]    exwb_rd;

    logic                     advance;
    assign advance = run && !halted;

    // ---------------- IF ----------------
    // Little-endian word assembled from four bytes; the address arithmetic
    // wraps naturally at the memory size.
    logic [PM_ADDR_WIDTH-1:0] pc_b1, pc_b2, pc_b3;
    logic [31:0]              fetch_inst;

    assign pc_b1      = pc + PM_ADDR_WIDTH'(1);
    assign pc_b2      = pc + PM_ADDR_WIDTH'(2);
    assign pc_b3      = pc + PM_ADDR_WIDTH'(3);
    assign fetch_inst = {pm[pc_b3], pm[pc_b2], pm[pc_b1], pm[pc]};

    // ---------------- ID: decode ----------------
    id_ex_ctrl_t              dec;
    logic [6:0]               dec_opcode;
    logic [2:0]               dec_f3;
    logic [6:0]               dec_f7;
    logic [XLEN-1:0]          dec_imm;
    logic [PM_ADDR_WIDTH-1:0] dec_br_target;

    assign dec_opcode = ifid_inst[6:0];
    assign dec_f3     = ifid_inst[14:12];
    assign dec_f7     = ifid_inst[31:25];

    // I-immediate sign-extended to 32 bits, then truncated to XLEN.
    assign dec_imm = XLEN'({{20{ifid_inst[31]}}, ifid_inst[31:20]});

    // B-immediate is a byte offset from the branch's own PC, wrapped.
    assign dec_br_target = ifid_pc + PM_ADDR_WIDTH'({{19{ifid_inst[31]}}, ifid_inst[31],
                                                     ifid_inst[7], ifid_inst[30:25],
                                                     ifid_inst[11:8], 1'b0});

    always_comb begin
        dec           = ID_EX_BUBBLE;
        dec.valid     = ifid_valid;
        dec.rd        = ifid_inst[11:7];
        dec.rs1       = ifid_inst[19:15];
        dec.rs2       = ifid_inst[24:20];
        unique case (dec_opcode)
            OPC_OP: begin
                if (dec_f7 == F7_BASE) begin
                    dec.writes = 1'b1;
                    case (dec_f3)
                        F3_ADD_SUB: dec.alu_op = ALU_ADD;
                        F3_SLL:     dec.alu_op = ALU_SLL;
                        F3_XOR:     dec.alu_op = ALU_XOR;
                        F3_SRL:     dec.alu_op = ALU_SRL;
                        F3_OR:      dec.alu_op = ALU_OR;
                        F3_AND:     dec.alu_op = ALU_AND;
                        default:    dec.writes = 1'b0;   // SLT/SLTU: not supported
                    endcase
                end else if (dec_f7 == F7_ALT && dec_f3 == F3_ADD_SUB) begin
                    dec.writes = 1'b1;
                    dec.alu_op = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                dec.use_imm = 1'b1;
                dec.writes  = 1'b1;
                case (dec_f3)
                    F3_ADD_SUB: dec.alu_op = ALU_ADD;
                    F3_XOR:     dec.alu_op = ALU_XOR;
                    F3_OR:      dec.alu_op = ALU_OR;
                    F3_AND:     dec.alu_op = ALU_AND;
                    F3_SLL: begin
                        dec.alu_op = ALU_SLL;
                        dec.writes = (dec_f7 == F7_BASE);
                    end
                    F3_SRL: begin
                        // funct7=0100000 would be SRAI, which is not supported.
                        dec.alu_op = ALU_SRL;
                        dec.writes = (dec_f7 == F7_BASE);
                    end
                    default:    dec.writes = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                if (dec_f3 == F3_BEQ || dec_f3 == F3_BNE) begin
                    dec.is_branch = 1'b1;
                    dec.br_ne     = (dec_f3 == F3_BNE);
                end
            end
            default: begin
                dec.is_ecall = (ifid_inst == INST_ECALL);
            end
        endcase
    end

    // ---------------- hazard unit ----------------
    logic ex_taken, ex_ecall;
    logic wb_we, fwd_rs1, fwd_rs2, wt_rs1, wt_rs2, flush_front;

    core_hazard_unit u_hazard (
        .exwb_valid  (exwb_valid),
        .exwb_rd     (exwb_rd),
        .idex_rs1    (idex.rs1),
        .idex_rs2    (idex.rs2),
        .ifid_rs1    (dec.rs1),
        .ifid_rs2    (dec.rs2),
        .ex_taken    (ex_taken),
        .ex_ecall    (ex_ecall),
        .wb_we       (wb_we),
        .fwd_rs1     (fwd_rs1),
        .fwd_rs2     (fwd_rs2),
        .wt_rs1      (wt_rs1),
        .wt_rs2      (wt_rs2),
        .flush_front (flush_front)
    );

    // ---------------- ID: register read with write-through ----------------
    logic [XLEN-1:0] id_rs1_val, id_rs2_val;

    always_comb begin
        if (dec.rs1 == '0)  id_rs1_val = '0;
        else if (wt_rs1)    id_rs1_val = alu_result;
        else                id_rs1_val = rf[dec.rs1[REG_AW-1:0]];

        if (dec.rs2 == '0)  id_rs2_val = '0;
        else if (wt_rs2)    id_rs2_val = alu_result;
        else                id_rs2_val = rf[dec.rs2[REG_AW-1:0]];
    end

    // ---------------- EX ----------------
    logic [XLEN-1:0] ex_op1, ex_rs2, ex_op2, ex_alu;
    logic [SH_W-1:0] ex_shamt;

    assign ex_op1   = fwd_rs1 ? alu_result : idex_rs1_val;
    assign ex_rs2   = fwd_rs2 ? alu_result : idex_rs2_val;
    assign ex_op2   = idex.use_imm ? idex_imm : ex_rs2;
    assign ex_shamt = ex_op2[SH_W-1:0];

    always_comb begin
        unique case (idex.alu_op)
            ALU_ADD:  ex_alu = ex_op1 + ex_op2;
            ALU_SUB:  ex_alu = ex_op1 - ex_op2;
            ALU_SLL:  ex_alu = ex_op1 << ex_shamt;
            ALU_XOR:  ex_alu = ex_op1 ^ ex_op2;
            ALU_SRL:  ex_alu = ex_op1 >> ex_shamt;
            ALU_OR:   ex_alu = ex_op1 | ex_op2;
            ALU_AND:  ex_alu = ex_op1 & ex_op2;
            default:  ex_alu = ex_op2;
        endcase
    end

    // BEQ compares rs1/rs2 (never the immediate); BNE inverts the sense.
    assign ex_taken = idex.valid && idex.is_branch && ((ex_op1 == ex_rs2) != idex.br_ne);
    assign ex_ecall = idex.valid && idex.is_ecall;

    // ---------------- program memory write port ----------------
    // Not reset; a write in the same cycle as a fetch of that byte lands
    // after the fetch, so the fetch sees the old byte.
    always_ff @(posedge clk) begin
        if (pm_wr_en) begin
            pm[pm_wr_addr] <= pm_wr_data;
        end
    end

    // ---------------- register file (WB write port) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (advance && wb_we) begin
            rf[exwb_rd[REG_AW-1:0]] <= alu_result;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= '0;
            ifid_valid     <= 1'b0;
            ifid_inst      <= '0;
            ifid_pc        <= '0;
            idex           <= ID_EX_BUBBLE;
            idex_rs1_val   <= '0;
            idex_rs2_val   <= '0;
            idex_imm       <= '0;
            idex_br_target <= '0;
            exwb_valid     <= 1'b0;
            exwb_rd        <= '0;
            alu_result     <= '0;
            halted         <= 1'b0;
            retired_count  <= '0;
        end else if (advance) begin
            // PC: a taken branch redirects, an ECALL in EX freezes fetch.
            if (ex_taken)      pc <= idex_br_target;
            else if (!ex_ecall) pc <= pc + PM_ADDR_WIDTH'(4);

            ifid_valid <= !flush_front;
            ifid_inst  <= fetch_inst;
            ifid_pc    <= pc;

            if (flush_front) idex <= ID_EX_BUBBLE;
            else             idex <= dec;
            idex_rs1_val   <= id_rs1_val;
            idex_rs2_val   <= id_rs2_val;
            idex_imm       <= dec_imm;
            idex_br_target <= dec_br_target;

            // alu_result only changes for writing instructions, so it holds
            // through branches, NOPs, ECALL and bubbles.
            exwb_valid <= idex.valid && idex.writes;
            exwb_rd    <= idex.rd;
            if (idex.valid && idex.writes) begin
                alu_result <= ex_alu;
            end

            if (idex.valid && (retired_count != '1)) begin
                retired_count <= retired_count + CNT_WIDTH'(1);
            end

            if (ex_ecall) begin
                halted <= 1'b1;
            end
        end
    end

    assign wb_valid = exwb_valid;
    assign dbg_pc   = pc;

endmodule
